conv_frame_ctrl: RTL and testbench
==================================

# conv_frame_ctrl

Frame-level sequencer for the streaming K_W x K_H convolution datapath (Sobel/Gaussian engine with line buffers). It accepts a raster pixel stream under a valid/ready handshake and applies downstream backpressure. It tracks the row and column of every accepted pixel and generates the shift enable for the line buffers and window registers. It flags each cycle in which a complete window is available, and signals end-of-frame once the datapath pipeline has drained.

## Interface
- Datawidth, 8, pixel width (pass-through only; no arithmetic on pixel data here)
- Img_W, 512, pixels per row
- Img_H, 512, rows per frame
- K_W, 3, kernel width
- K_H, 3, kernel height
- PIPE_LAT, 2, datapath latency in cycles from window-valid to result-valid
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  frame start request, sampled only in IDLE
- abort  in  1  synchronous frame abort
- in_valid  in  1  upstream pixel valid
- in_ready  out  1  controller can accept a pixel
- out_ready  in  1  downstream can accept a result
- pix_en  out  1  line-buffer/window shift enable = in_valid & in_ready
- row  out  clog2(Img_H)  row of the next pixel to be accepted
- col  out  clog2(Img_W)  column of the next pixel to be accepted
- win_valid  out  1  complete window present in window registers
- win_row  out  clog2(Img_H)  top-left row of the current window
- win_col  out  clog2(Img_W)  top-left column of the current window
- busy  out  1  high in RUN and DRAIN
- frame_done  out  1  one-cycle end-of-frame pulse

## Operation
- States: IDLE, RUN, DRAIN, DONE. Encoding is free.
- IDLE: in_ready=0. start=1 -> RUN, with row and col cleared to 0.
- RUN: in_ready = out_ready, combinational. An accept is in_valid & in_ready.
  - On accept: col increments; at col==Img_W-1 it wraps to 0 and row increments.
  - Accept of pixel (Img_H-1, Img_W-1) -> DRAIN. row and col return to 0.
- DRAIN: in_ready=0. A counter loads PIPE_LAT and decrements once per cycle. Reaching 0 -> DONE. PIPE_LAT=0 goes directly to DONE on the next cycle.
- DONE: frame_done=1 for exactly one cycle, then IDLE.
- Window rule: on an accept of pixel (r,c) with r>=K_H-1 and c>=K_W-1, the controller drives these values in the next cycle:
  - win_valid=1
  - win_row = r-(K_H-1)
  - win_col = c-(K_W-1)
- In any cycle without a qualifying accept, win_valid=0 and win_row/win_col hold their values.
- Windows per frame: exactly (Img_W-K_W+1)*(Img_H-K_H+1). There are no border windows and no padding.
- abort, in RUN/DRAIN/DONE: next state IDLE, row/col cleared, win_valid=0, no frame_done. abort has priority over an accept and over start in the same cycle; the pixel is not counted.
- start outside IDLE is ignored. start and abort together in IDLE: remain IDLE.
- in_valid while not RUN is ignored. in_ready=0 holds off upstream.
- Column/row arithmetic is unsigned. Widths use clog2 with a minimum of 1 bit. Counters never exceed Img_W-1 / Img_H-1.

## Timing
- Reset, asynchronous and low: state=IDLE; row=col=0; win_row=win_col=0; win_valid=0; frame_done=0; busy=0; DRAIN counter=0. in_ready=0 and pix_en=0 follow from the state.
- Reset asserted mid-frame takes effect immediately. After deassertion the controller idles until the next start.
- in_ready and pix_en are combinational from state, out_ready and in_valid. All other outputs are registered.
- win_valid latency: 1 cycle after the qualifying accept.
- frame_done latency, measured from the last-pixel accept cycle T: DRAIN occupies T+1..T+PIPE_LAT, and frame_done is asserted at T+PIPE_LAT+1.
- Throughput: 1 pixel/cycle when in_valid=out_ready=1 continuously.
- out_ready=0 stalls acceptance with no state change. Bubbles on in_valid or out_ready do not alter counts.
- busy=1 from the cycle after start is accepted through the last DRAIN cycle. busy=0 in DONE.

## Test plan
Small parameters for all scenarios: Img_W=8, Img_H=6, K_W=K_H=3, PIPE_LAT=2, so one frame is 48 pixels and 24 windows.
- Continuous stream: start, then in_valid=out_ready=1 for 48 cycles. Expect:
  - first win_valid 1 cycle after the accept of (2,2), with win_row=0, win_col=0
  - exactly 24 win_valid pulses, the last with win_row=3, win_col=5
  - frame_done 3 cycles after the 48th accept
  - busy low afterwards
- Random bubbles: in_valid and out_ready each toggled randomly at 50%. Expect:
  - pix_en count=48 and win_valid count=24
  - no accept while out_ready=0
  - window coordinates in raster order
- Row wrap: after accepting (0,7), expect col=0 and row=1. Across the row boundary, no win_valid for accepts at c<2.
- Abort at pixel 20 with in_valid=1 in the same cycle. Expect:
  - pix_en=0 that cycle and IDLE next cycle
  - row=col=0 and no frame_done
  - the next start runs a clean full frame with 24 windows
- Async reset low for a half-cycle mid-RUN, off a clock edge. Expect all outputs at reset values immediately, with start required to resume.
- start pulsed during RUN and DRAIN: ignored, with window/pixel counts unchanged. start in the DONE cycle: ignored, IDLE follows.

Source files
------------

// File: rtl/conv_frame_ctrl.sv
// Frame-level sequencer for a streaming KW x KH convolution datapath: raster pixel
// tracking, line-buffer shift enable, window-valid flagging and drain/end-of-frame.
module conv_frame_ctrl #(
  parameter int unsigned ImgW    = 512,
  parameter int unsigned ImgH    = 512,
  parameter int unsigned KW      = 3,
  parameter int unsigned KH      = 3,
  parameter int unsigned PipeLat = 2,
  localparam int unsigned RowW   = (ImgH > 1) ? $clog2(ImgH) : 1,
  localparam int unsigned ColW   = (ImgW > 1) ? $clog2(ImgW) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic            out_ready_i,
  output logic            pix_en_o,
  output logic [RowW-1:0] row_o,
  output logic [ColW-1:0] col_o,
  output logic            win_valid_o,
  output logic [RowW-1:0] win_row_o,
  output logic [ColW-1:0] win_col_o,
  output logic            busy_o,
  output logic            frame_done_o
);

  localparam int unsigned CntW = (PipeLat > 1) ? $clog2(PipeLat + 1) : 1;

  localparam logic [RowW-1:0] RowLast = RowW'(ImgH - 1);
  localparam logic [ColW-1:0] ColLast = ColW'(ImgW - 1);
  localparam logic [RowW-1:0] RowKOff = RowW'(KH - 1);
  localparam logic [ColW-1:0] ColKOff = ColW'(KW - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e          state_q;
  logic [RowW-1:0] row_q, win_row_q;
  logic [ColW-1:0] col_q, win_col_q;
  logic [CntW-1:0] cnt_q;
  logic            win_valid_q, busy_q, frame_done_q;

  logic accept, win_hit, col_last, row_last;

  // Abort gates the handshake so an aborted cycle never shifts the line buffers.
  assign in_ready_o = (state_q == StRun) && out_ready_i && !abort_i;
  assign pix_en_o   = in_valid_i && in_ready_o;
  assign accept     = pix_en_o;
  assign win_hit    = (row_q >= RowKOff) && (col_q >= ColKOff);
  assign col_last   = (col_q == ColLast);
  assign row_last   = (row_q == RowLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      row_q        <= '0;
      col_q        <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      win_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (abort_i && (state_q != StIdle)) begin
        state_q <= StIdle;
        row_q   <= '0;
        col_q   <= '0;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_i && !abort_i) begin
              state_q <= StRun;
              row_q   <= '0;
              col_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          StRun: begin
            if (accept) begin
              if (win_hit) begin
                win_valid_q <= 1'b1;
                win_row_q   <= row_q - RowKOff;
                win_col_q   <= col_q - ColKOff;
              end
              if (col_last) begin
                col_q <= '0;
                if (row_last) begin
                  row_q <= '0;
                  if (PipeLat == 0) begin
                    state_q      <= StDone;
                    busy_q       <= 1'b0;
                    frame_done_q <= 1'b1;
                  end else begin
                    state_q <= StDrain;
                    cnt_q   <= CntW'(PipeLat);
                  end
                end else begin
                  row_q <= row_q + 1'b1;
                end
              end else begin
                col_q <= col_q + 1'b1;
              end
            end
          end
          StDrain: begin
            // Last drain cycle is the one where the counter steps down to zero.
            if (cnt_q <= CntW'(1)) begin
              state_q      <= StDone;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
              cnt_q        <= '0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          StDone: state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign row_o        = row_q;
  assign col_o        = col_q;
  assign win_valid_o  = win_valid_q;
  assign win_row_o    = win_row_q;
  assign win_col_o    = win_col_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Scoreboard bench for conv_frame_ctrl on an 8x6 frame with a 3x3 kernel and two-cycle drain.
module tb_conv_frame_ctrl;

  localparam int ImgW = 8;
  localparam int ImgH = 6;

  logic       clk, rst_n, start, abort, in_valid, out_ready;
  logic       in_ready, pix_en, win_valid, busy, frame_done;
  logic [2:0] row, col, win_row, win_col;

  conv_frame_ctrl #(
    .ImgW(ImgW), .ImgH(ImgH), .KW(3), .KH(3), .PipeLat(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .out_ready_i(out_ready),
    .pix_en_o(pix_en), .row_o(row), .col_o(col), .win_valid_o(win_valid),
    .win_row_o(win_row), .win_col_o(win_col), .busy_o(busy), .frame_done_o(frame_done)
  );

  typedef struct { int r; int c; int cy; } win_t;
  win_t q[$];

  int n_chk = 0, n_fail = 0, n_win = 0, n_acc = 0, n_done = 0, cyc = 0, last_cyc = 0;
  int m_row = 0, m_col = 0;
  bit m_run = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected windows whenever the DUT flags one.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cy < cyc) begin
      n_chk++; n_fail++;
      $display("FAIL win_missing: got none expected (%0d,%0d) at cycle %0d",
               q[0].r, q[0].c, q[0].cy);
      void'(q.pop_front());
    end
    if (win_valid === 1'b1) begin
      n_win++;
      if (q.size() == 0) begin
        chk("win_unexpected", 1, 0);
      end else begin
        win_t e;
        e = q.pop_front();
        chk("win_row", win_row, e.r);
        chk("win_col", win_col, e.c);
        chk("win_cycle", cyc, e.cy);
      end
    end
    if (frame_done === 1'b1) n_done++;
  end

  // One cycle of stimulus; checks position and handshake against the pixel model.
  task automatic px(input bit v, input bit r, input bit s, input bit a);
    bit exp_acc;
    @(posedge clk); #1;
    in_valid = v; out_ready = r; start = s; abort = a;
    @(negedge clk);
    chk("row", row, m_row);
    chk("col", col, m_col);
    exp_acc = m_run && v && r && !a;
    chk("pix_en", pix_en, exp_acc);
    if (a) begin
      m_run = 0; m_row = 0; m_col = 0;
    end else if (exp_acc) begin
      n_acc++;
      if (m_row >= 2 && m_col >= 2) q.push_back('{m_row - 2, m_col - 2, cyc + 1});
      if (m_col == ImgW - 1) begin
        m_col = 0;
        if (m_row == ImgH - 1) begin
          m_row = 0; m_run = 0; last_cyc = cyc;
        end else m_row++;
      end else m_col++;
    end
  endtask

  task automatic do_start();
    px(0, 1, 1, 0);
    m_run = 1; m_row = 0; m_col = 0;
  endtask

  task automatic wait_done(input bit s);
    bit got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      px(1, 1, s, 0);
      if (k == 0) chk("busy_drain", busy, 1);
      if (frame_done === 1'b1) begin
        got = 1;
        chk("done_latency", cyc - last_cyc, 3);
        chk("busy_in_done", busy, 0);
      end
    end
    if (!got) chk("frame_done_seen", 0, 1);
    px(1, 1, 0, 0);
    chk("done_one_cycle", frame_done, 0);
    chk("busy_idle", busy, 0);
    px(1, 1, 0, 0);
    chk("busy_idle2", busy, 0);
    px(0, 0, 0, 0);
  endtask

  task automatic full_frame(input bit s);
    int w0 = n_win, a0 = n_acc;
    do_start();
    for (int i = 0; i < 48; i++) begin
      px(1, 1, s && (i == 10), 0);
      if (i == 0) chk("busy_run", busy, 1);
    end
    wait_done(s);
    chk("frame_accepts", n_acc - a0, 48);
    chk("frame_windows", n_win - w0, 24);
    chk("queue_empty", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w0, a0, d0;
    rst_n = 1'b1; start = 0; abort = 0; in_valid = 0; out_ready = 0;
    #2 rst_n = 1'b0;
    in_valid = 1; out_ready = 1;
    #20;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_pix_en", pix_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_row", row, 0);
    chk("rst_col", col, 0);
    chk("rst_win_rowcol", {win_row, win_col}, 0);
    rst_n = 1'b1;

    // start together with abort in IDLE stays idle
    px(0, 1, 1, 1);
    px(1, 1, 0, 0);
    chk("start_abort_idle", busy, 0);

    full_frame(0);

    // Random bubbles, with start pulsed in RUN, DRAIN and DONE
    w0 = n_win; a0 = n_acc;
    do_start();
    for (int i = 0; i < 2000 && m_run; i++)
      px(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), i == 5, 0);
    chk("bubble_accepts", n_acc - a0, 48);
    wait_done(1);
    chk("bubble_windows", n_win - w0, 24);

    // Abort on pixel 20 with in_valid high
    w0 = n_win; d0 = n_done;
    do_start();
    for (int i = 0; i < 20; i++) px(1, 1, 0, 0);
    px(1, 1, 0, 1);
    px(1, 1, 0, 0);
    chk("abort_busy", busy, 0);
    chk("abort_win_valid", win_valid, 0);
    for (int i = 0; i < 5; i++) px(0, 0, 0, 0);
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_windows", n_win - w0, 2);
    full_frame(0);

    // Asynchronous reset mid-RUN, off the clock edge
    do_start();
    for (int i = 0; i < 13; i++) px(1, 1, 0, 0);
    @(posedge clk); #3;
    rst_n = 1'b0; in_valid = 1; out_ready = 1;
    #1;
    q.delete();
    m_run = 0; m_row = 0; m_col = 0;
    chk("arst_row", row, 0);
    chk("arst_col", col, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_pix_en", pix_en, 0);
    chk("arst_win_valid", win_valid, 0);
    #4 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) px(1, 1, 0, 0);
    chk("arst_stays_idle", busy, 0);
    full_frame(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
